// File: rtl/axi_pkg.sv
// AXI3 read-channel constants, the AR request record and the AR state type
// used by the read arbiter.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
  localparam logic [2:0] AXI_PROT_NONE   = 3'b000;
  localparam logic [3:0] AXI_CACHE_NONE  = 4'b0000;
  localparam logic [3:0] AXI_CACHE_ALL   = 4'b1111;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        uncached;
  } ar_req_t;

  typedef enum logic {AR_IDLE, AR_ADDR} ar_state_t;

  function automatic logic [3:0] ar_cache(input logic uncached);
    return uncached ? AXI_CACHE_NONE : AXI_CACHE_ALL;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way arbiter: round-robin by default, fixed lowest-index priority when
// AXI_RD_ARB_FIXED_PRIO_EN is defined. One-hot grant, pointer moves on adv_i.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req_i,
  input  logic         adv_i,
  output logic [N-1:0] gnt_o
);

`ifdef AXI_RD_ARB_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = clk ^ rst_n ^ adv_i;

  // Scanning downwards lets the lowest requesting index overwrite the rest.
  always_comb begin
    gnt_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

`else

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] last_q, last_d, idx;
  logic          found;

  // NOTE: every variable gets a default at the top of the block so no path
  // through the loop leaves a latch behind.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_q) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (adv_i) begin
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) last_d = IW'(k);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= IW'(N - 1);
    else        last_q <= last_d;
  end

`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// AXI3 read arbiter: N clients share one AR/R master port, one outstanding
// burst per client. Build with AXI_RD_ARB_FIXED_PRIO_EN for fixed priority.
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int N_CLIENTS = 3,
  parameter int ID_W      = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [N_CLIENTS-1:0]   c_req,
  output logic [N_CLIENTS-1:0]   c_gnt,
  input  logic [N_CLIENTS*32-1:0] c_addr,
  input  logic [N_CLIENTS*8-1:0] c_len,
  input  logic [N_CLIENTS*3-1:0] c_size,
  input  logic [N_CLIENTS-1:0]   c_uncached,
  output logic [N_CLIENTS-1:0]   c_rvalid,
  output logic [N_CLIENTS-1:0]   c_rlast,
  output logic [N_CLIENTS-1:0]   c_rerr,
  input  logic [N_CLIENTS-1:0]   c_rready,
  output logic [31:0]            c_rdata,
  output logic [ID_W-1:0]        arid,
  output logic [31:0]            araddr,
  output logic [3:0]             arlen,
  output logic [2:0]             arsize,
  output logic [1:0]             arburst,
  output logic [1:0]             arlock,
  output logic [3:0]             arcache,
  output logic [2:0]             arprot,
  output logic                   arvalid,
  input  logic                   arready,
  input  logic [ID_W-1:0]        rid,
  input  logic [31:0]            rdata,
  input  logic [1:0]             rresp,
  input  logic                   rlast,
  input  logic                   rvalid,
  output logic                   rready
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  ar_state_t              state_q, state_d;
  ar_req_t                hold_q, hold_d;
  logic [IW-1:0]          win_q, win_d;
  logic [N_CLIENTS-1:0]   busy_q, busy_d, arb_req, arb_gnt;
  logic                   grant, ar_hs, unused_bits;

  assign arb_req = (state_q == AR_IDLE) ? (c_req & ~busy_q) : '0;

  rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .clk   (aclk),
    .rst_n (aresetn),
    .req_i (arb_req),
    .adv_i (grant),
    .gnt_o (arb_gnt)
  );

  assign grant = |arb_gnt;
  // The grant is combinational on c_req, so it is masked while reset is held.
  assign c_gnt = arb_gnt & {N_CLIENTS{aresetn}};
  assign ar_hs = (state_q == AR_ADDR) && arready;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    win_d   = win_q;
    case (state_q)
      AR_IDLE: if (grant)   state_d = AR_ADDR;
      AR_ADDR: if (arready) state_d = AR_IDLE;
      default:              state_d = AR_IDLE;
    endcase
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (arb_gnt[k]) begin
        hold_d.addr     = c_addr[k*32 +: 32];
        hold_d.len      = c_len[k*8 +: 8];
        hold_d.size     = c_size[k*3 +: 3];
        hold_d.uncached = c_uncached[k];
        win_d           = IW'(k);
      end
    end
  end

  // Set and clear come from different clients, so both may act in one cycle.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (rvalid && rready && rlast && (rid == ID_W'(k))) busy_d[k] = 1'b0;
      if (ar_hs && (win_q == IW'(k)))                     busy_d[k] = 1'b1;
    end
  end

  // Beats with an ID outside the client range are accepted and dropped.
  always_comb begin
    rready   = 1'b1;
    c_rvalid = '0;
    c_rlast  = '0;
    c_rerr   = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (rid == ID_W'(k)) begin
        rready      = c_rready[k];
        c_rvalid[k] = rvalid;
        c_rlast[k]  = rlast;
        c_rerr[k]   = rvalid && rresp[1];
      end
    end
  end

  // NOTE: the AR holding register is reset too, so araddr and friends read as
  // zero out of reset instead of carrying X into downstream logic.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= AR_IDLE;
      hold_q  <= '0;
      win_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      win_q   <= win_d;
      busy_q  <= busy_d;
    end
  end

  assign arvalid = (state_q == AR_ADDR);
  assign arid    = ID_W'(win_q);
  assign araddr  = hold_q.addr;
  assign arlen   = hold_q.len[3:0];
  assign arsize  = hold_q.size;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_LOCK_NORMAL;
  assign arcache = ar_cache(hold_q.uncached);
  assign arprot  = AXI_PROT_NONE;
  assign c_rdata = rdata;

  // AXI3 carries a 4-bit burst length; only rresp[1] separates error codes.
  assign unused_bits = ^{hold_q.len[7:4], rresp[0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: R-routing vector table, directed
// corner sequences and a randomized run against a transaction-level model.
module tb_axi_rd_arbiter;

  localparam int N    = 3;
  localparam int ID_W = 4;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [N-1:0]      c_req, c_gnt, c_uncached, c_rvalid, c_rlast, c_rerr, c_rready;
  logic [N*32-1:0]   c_addr;
  logic [N*8-1:0]    c_len;
  logic [N*3-1:0]    c_size;
  logic [31:0]       c_rdata, araddr, rdata;
  logic [ID_W-1:0]   arid, rid;
  logic [3:0]        arlen, arcache;
  logic [2:0]        arsize, arprot;
  logic [1:0]        arburst, arlock, rresp;
  logic              arvalid, arready, rlast, rvalid, rready;

  axi_rd_arbiter #(.N_CLIENTS(N), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn), .c_req(c_req), .c_gnt(c_gnt),
    .c_addr(c_addr), .c_len(c_len), .c_size(c_size), .c_uncached(c_uncached),
    .c_rvalid(c_rvalid), .c_rlast(c_rlast), .c_rerr(c_rerr),
    .c_rready(c_rready), .c_rdata(c_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model: who is outstanding, beats left, pending AR.
  logic [N-1:0] m_busy;
  int           m_rem [N];
  int           m_last;
  bit           m_pend;
  int           m_pid;
  logic [31:0]  m_paddr;
  logic [7:0]   m_plen;
  logic [2:0]   m_psize;
  logic         m_punc;
  int           last_gnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] elig);
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (elig[i]) return i;
`else
    for (int i = 1; i <= N; i++) begin
      int k = (m_last + i) % N;
      if (elig[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = '0;
    m_pend = 1'b0;
    m_last = N - 1;
    m_pid  = 0;
    for (int k = 0; k < N; k++) m_rem[k] = 0;
  endtask

  task automatic drive_idle();
    c_req = '0; c_addr = '0; c_len = '0; c_size = '0; c_uncached = '0;
    c_rready = '1; arready = 1'b0;
    rvalid = 1'b0; rlast = 1'b0; rid = '0; rresp = '0; rdata = '0;
  endtask

  task automatic set_client(input int k, input logic [31:0] a, input logic [7:0] l,
                            input logic [2:0] s, input logic u);
    c_addr[k*32 +: 32] = a;
    c_len[k*8 +: 8]    = l;
    c_size[k*3 +: 3]   = s;
    c_uncached[k]      = u;
  endtask

  task automatic set_beat(input int id, input logic last, input logic [1:0] resp);
    rvalid = 1'b1;
    rid    = ID_W'(id);
    rlast  = last;
    rresp  = resp;
    rdata  = $urandom;
  endtask

  // Leaves the bench just after a falling edge with reset released.
  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
  endtask

  // Checks every output against the model, then predicts the coming edge.
  task automatic eval();
    int           w, r;
    logic [N-1:0] elig, e_gnt, e_rv, e_rl, e_err;
    logic         e_rdy, inr;
    #1;
    elig  = c_req & ~m_busy;
    w     = m_pend ? -1 : pick(elig);
    e_gnt = '0;
    if (w >= 0) e_gnt[w] = 1'b1;
    check("c_gnt", c_gnt, e_gnt);
    check("arvalid", arvalid, m_pend);
    if (m_pend) begin
      check("arid", arid, m_pid);
      check("araddr", araddr, m_paddr);
      check("arlen", arlen, m_plen[3:0]);
      check("arsize", arsize, m_psize);
      check("arcache", arcache, m_punc ? 4'h0 : 4'hf);
      check("ar_consts", {arburst, arlock, arprot}, {2'b01, 2'b00, 3'b000});
    end
    inr = (rid < N);
    r   = int'(rid);
    e_rdy = 1'b1; e_rv = '0; e_rl = '0; e_err = '0;
    if (inr) begin
      e_rdy = c_rready[r];
      e_rv[r]  = rvalid;
      e_rl[r]  = rlast;
      e_err[r] = rvalid && rresp[1];
    end
    check("rready", rready, e_rdy);
    check("c_rvalid", c_rvalid, e_rv);
    check("c_rlast", c_rlast, e_rl);
    check("c_rerr", c_rerr, e_err);
    check("c_rdata", c_rdata, rdata);
    last_gnt = w;
    if (rvalid && e_rdy && inr) begin
      if (rlast) begin m_busy[r] = 1'b0; m_rem[r] = 0; end
      else m_rem[r]--;
    end
    if (w >= 0) begin
      m_pend  = 1'b1;
      m_pid   = w;
      m_last  = w;
      m_paddr = c_addr[w*32 +: 32];
      m_plen  = c_len[w*8 +: 8];
      m_psize = c_size[w*3 +: 3];
      m_punc  = c_uncached[w];
    end else if (m_pend && arready) begin
      m_pend        = 1'b0;
      m_busy[m_pid] = 1'b1;
      m_rem[m_pid]  = int'(m_plen[3:0]) + 1;
    end
  endtask

  task automatic rand_inputs();
    int q[$];
    int r;
    c_req      = N'($urandom_range(0, 7));
    c_addr     = {$urandom, $urandom, $urandom};
    c_len      = 24'($urandom);
    c_size     = 9'($urandom);
    c_uncached = N'($urandom);
    arready    = 1'($urandom_range(0, 1));
    c_rready   = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
    rdata      = $urandom;
    rresp      = 2'($urandom);
    for (int k = 0; k < N; k++) if (m_rem[k] > 0) q.push_back(k);
    r = $urandom_range(0, 9);
    if (q.size() > 0 && r < 6) begin
      r      = q[$urandom_range(0, q.size() - 1)];
      rvalid = 1'b1;
      rid    = ID_W'(r);
      rlast  = (m_rem[r] == 1);
    end else if (r == 9) begin
      rvalid = 1'b1;
      rid    = ID_W'($urandom_range(N, 15));
      rlast  = 1'($urandom_range(0, 1));
    end else begin
      rvalid = 1'b0;
      rlast  = 1'b0;
      rid    = ID_W'($urandom_range(0, 15));
    end
  endtask

  typedef struct {
    logic [ID_W-1:0] rid;
    logic            rv, rl;
    logic [1:0]      resp;
    logic [N-1:0]    rdy, e_rv, e_rl, e_err;
    logic            e_rready;
  } rvec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rvec_t tbl [10];
    int    got[$];
    int    exp_seq [4];

    tbl[0] = '{4'd0,  1'b1, 1'b0, 2'b00, 3'b111, 3'b001, 3'b000, 3'b000, 1'b1};
    tbl[1] = '{4'd2,  1'b1, 1'b0, 2'b00, 3'b111, 3'b100, 3'b000, 3'b000, 1'b1};
    tbl[2] = '{4'd0,  1'b1, 1'b0, 2'b10, 3'b111, 3'b001, 3'b000, 3'b001, 1'b1};
    tbl[3] = '{4'd2,  1'b1, 1'b1, 2'b00, 3'b111, 3'b100, 3'b100, 3'b000, 1'b1};
    tbl[4] = '{4'd0,  1'b1, 1'b1, 2'b01, 3'b110, 3'b001, 3'b001, 3'b000, 1'b0};
    tbl[5] = '{4'd2,  1'b1, 1'b0, 2'b11, 3'b011, 3'b100, 3'b000, 3'b100, 1'b0};
    tbl[6] = '{4'd3,  1'b1, 1'b1, 2'b10, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[7] = '{4'd15, 1'b1, 1'b0, 2'b00, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1};
    tbl[8] = '{4'd1,  1'b0, 1'b0, 2'b10, 3'b101, 3'b000, 3'b000, 3'b000, 1'b0};
    tbl[9] = '{4'd1,  1'b1, 1'b0, 2'b00, 3'b010, 3'b010, 3'b000, 3'b000, 1'b1};
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 1, 2, 0};
`endif

    aresetn = 1'b0;
    drive_idle();
    model_reset();
    #1;
    check("reset_arvalid", arvalid, 1'b0);
    check("reset_araddr", araddr, 32'h0);
    check("reset_busy", dut.busy_q, 3'b000);
    do_reset();

    // Combinational R routing, no requests outstanding.
    for (int i = 0; i < 10; i++) begin
      rid = tbl[i].rid; rvalid = tbl[i].rv; rlast = tbl[i].rl;
      rresp = tbl[i].resp; c_rready = tbl[i].rdy; rdata = $urandom;
      #1;
      check("tbl_c_rvalid", c_rvalid, tbl[i].e_rv);
      check("tbl_c_rlast", c_rlast, tbl[i].e_rl);
      check("tbl_c_rerr", c_rerr, tbl[i].e_err);
      check("tbl_rready", rready, tbl[i].e_rready);
      check("tbl_c_rdata", c_rdata, rdata);
    end

    // Single cached 4-beat read from client 0.
    do_reset();
    c_req = 3'b001; arready = 1'b1;
    set_client(0, 32'h1c00_0000, 8'd3, 3'd2, 1'b0);
    eval();
    check("s1_gnt", c_gnt, 3'b001);
    @(negedge aclk);
    c_req = '0; c_addr = {$urandom, $urandom, $urandom};
    eval();
    check("s1_gnt_pulse", c_gnt, 3'b000);
    check("s1_arvalid", arvalid, 1'b1);
    check("s1_arid", arid, 4'd0);
    check("s1_arcache", arcache, 4'hf);
    check("s1_araddr", araddr, 32'h1c00_0000);
    @(negedge aclk);
    arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      set_beat(0, b == 3, 2'b00);
      eval();
      check("s1_rvalid", c_rvalid, 3'b001);
      check("s1_rlast", c_rlast, (b == 3) ? 3'b001 : 3'b000);
      if (b == 0) check("s1_busy_set", dut.busy_q, 3'b001);
      @(negedge aclk);
    end
    rvalid = 1'b0; rlast = 1'b0;
    eval();
    check("s1_busy_clr", dut.busy_q, 3'b000);

    // All three clients requesting continuously; each burst is one beat.
    do_reset();
    c_req = 3'b111; arready = 1'b1;
    for (int k = 0; k < N; k++) set_client(k, $urandom, 8'd0, 3'd2, 1'($urandom));
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      rvalid = 1'b0; rlast = 1'b0;
      for (int k = N - 1; k >= 0; k--) if (m_busy[k]) set_beat(k, 1'b1, 2'b00);
      eval();
      if (last_gnt >= 0) got.push_back(last_gnt);
      @(negedge aclk);
    end
    check("arb_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) check("arb_order", got[i], exp_seq[i]);

    // Busy client 1 keeps requesting: no grant until its rlast handshake.
    do_reset();
    c_req = 3'b010; arready = 1'b1;
    set_client(1, 32'h0000_4000, 8'd1, 3'd2, 1'b1);
    eval();
    check("s3_gnt", c_gnt, 3'b010);
    @(negedge aclk);
    eval();
    check("s3_arcache", arcache, 4'h0);
    @(negedge aclk);
    for (int c = 0; c < 5; c++) begin
      eval();
      check("s3_blocked", c_gnt, 3'b000);
      @(negedge aclk);
    end
    set_beat(1, 1'b0, 2'b00);
    eval();
    check("s3_mid_beat", c_gnt, 3'b000);
    @(negedge aclk);
    set_beat(1, 1'b1, 2'b00);
    eval();
    check("s3_last_beat", c_gnt, 3'b000);
    @(negedge aclk);
    rvalid = 1'b0; rlast = 1'b0;
    eval();
    check("s3_regrant", c_gnt, 3'b010);
    @(negedge aclk);

    // Reset while an AR waits for arready, with client 2 outstanding.
    do_reset();
    c_req = 3'b100; arready = 1'b1;
    set_client(2, 32'h0000_8000, 8'd7, 3'd2, 1'b0);
    eval();
    @(negedge aclk);
    eval();
    @(negedge aclk);
    c_req = 3'b001; arready = 1'b0;
    set_client(0, 32'h0000_1000, 8'd0, 3'd2, 1'b0);
    eval();
    check("s4_gnt0", c_gnt, 3'b001);
    @(negedge aclk);
    eval();
    check("s4_addr_wait", arvalid, 1'b1);
    check("s4_busy_pre", dut.busy_q, 3'b100);
    aresetn = 1'b0;
    model_reset();
    #1;
    check("s4_rst_arvalid", arvalid, 1'b0);
    check("s4_rst_busy", dut.busy_q, 3'b000);
    check("s4_rst_gnt", c_gnt, 3'b000);
    @(negedge aclk);
    aresetn = 1'b1; arready = 1'b1;
    eval();
    check("s4_post_gnt", c_gnt, 3'b001);
    @(negedge aclk);
    eval();
    check("s4_post_arid", arid, 4'd0);
    @(negedge aclk);

    // Randomized traffic with occasional asynchronous resets.
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rand_inputs();
      eval();
      if ($urandom_range(0, 299) == 0) begin
        aresetn = 1'b0;
        model_reset();
        #1;
        check("rnd_rst_arvalid", arvalid, 1'b0);
        check("rnd_rst_gnt", c_gnt, 3'b000);
        check("rnd_rst_busy", dut.busy_q, 3'b000);
        @(negedge aclk);
        aresetn = 1'b1;
      end else begin
        @(negedge aclk);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
